// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port (fetch/data) arbiter for a single-port synchronous RAM with OOB trap
// Optional MEM_ARB_RR_EN: round-robin arbitration instead of fixed data-over-fetch priority.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 64,
    parameter int MEM_WORDS  = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fetch_req,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    output logic                  fetch_gnt,
    output logic                  fetch_valid,
    output logic [DATA_WIDTH-1:0] fetch_data,
    input  logic                  flush,
    input  logic                  data_req,
    input  logic                  data_we,
    input  logic [ADDR_WIDTH-1:0] data_addr,
    input  logic [DATA_WIDTH-1:0] data_wdata,
    output logic                  data_gnt,
    output logic                  data_valid,
    output logic [DATA_WIDTH-1:0] data_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  trap
);

    typedef enum logic {RUN, TRAPPED} state_t;

    localparam logic [ADDR_WIDTH:0] MEM_LIMIT = (ADDR_WIDTH + 1)'(MEM_WORDS);

    state_t state;
    logic   fetch_pend;
    logic   data_rd;
    logic   pick_data;
    logic   pick_fetch;
    logic   data_oob;
`ifdef MEM_ARB_RR_EN
    logic   last_data;
`endif

    always_comb begin
`ifdef MEM_ARB_RR_EN
        pick_data = data_req && (!fetch_req || !last_data);
`else
        pick_data = data_req;
`endif
        pick_fetch = fetch_req && !pick_data;
        data_oob   = {1'b0, data_addr} >= MEM_LIMIT;
    end

    // RAM read data is passed straight through; valids qualify it.
    assign fetch_data  = mem_rdata;
    assign data_rdata  = mem_rdata;
    // A flush in the cycle the read data returns must still kill it.
    assign fetch_valid = fetch_pend && !flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= RUN;
            fetch_gnt  <= 1'b0;
            data_gnt   <= 1'b0;
            data_valid <= 1'b0;
            data_rd    <= 1'b0;
            fetch_pend <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            trap       <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_data  <= 1'b0;
`endif
        end else begin
            fetch_gnt  <= 1'b0;
            data_gnt   <= 1'b0;
            mem_we     <= 1'b0;
            data_rd    <= 1'b0;
            data_valid <= data_rd;
            fetch_pend <= fetch_gnt && !flush;
            case (state)
                RUN: begin
                    if (pick_data) begin
                        data_gnt  <= 1'b1;
                        mem_addr  <= data_addr;
                        mem_wdata <= data_wdata;
`ifdef MEM_ARB_RR_EN
                        last_data <= 1'b1;
`endif
                        if (data_oob) begin
                            state <= TRAPPED;
                            trap  <= 1'b1;
                        end else begin
                            mem_we  <= data_we;
                            data_rd <= !data_we;
                        end
                    end else if (pick_fetch) begin
                        fetch_gnt <= 1'b1;
                        mem_addr  <= fetch_addr;
`ifdef MEM_ARB_RR_EN
                        last_data <= 1'b0;
`endif
                    end
                end
                default: begin
                    state <= TRAPPED;
                    trap  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter with a behavioural RAM
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_req;
    logic [15:0] fetch_addr;
    logic        fetch_gnt;
    logic        fetch_valid;
    logic [63:0] fetch_data;
    logic        flush;
    logic        data_req;
    logic        data_we;
    logic [15:0] data_addr;
    logic [63:0] data_wdata;
    logic        data_gnt;
    logic        data_valid;
    logic [63:0] data_rdata;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic        trap;

    logic [63:0] ram [0:1023];
    int checks = 0;
    int errors = 0;

    mem_arbiter dut (
        .clk(clk), .reset(reset),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
        .fetch_valid(fetch_valid), .fetch_data(fetch_data), .flush(flush),
        .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_gnt(data_gnt), .data_valid(data_valid),
        .data_rdata(data_rdata), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .trap(trap)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr[9:0]] <= mem_wdata;
        mem_rdata <= ram[mem_addr[9:0]];
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic half();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        int n_data;
        int n_fetch;
        for (int i = 0; i < 1024; i++) ram[i] = 64'(i);
        ram[16] = 64'h0123456789ABCDEF;
        mem_rdata = '0;
        reset = 1'b1; fetch_req = 1'b0; fetch_addr = '0; flush = 1'b0;
        data_req = 1'b0; data_we = 1'b0; data_addr = '0; data_wdata = '0;
        cyc(); cyc();
        half();
        chk("rst_fetch_gnt", 64'(fetch_gnt), 64'd0);
        chk("rst_data_gnt", 64'(data_gnt), 64'd0);
        chk("rst_mem_we", 64'(mem_we), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_mem_wdata", mem_wdata, 64'd0);
        chk("rst_trap", 64'(trap), 64'd0);
        chk("rst_valids", 64'({fetch_valid, data_valid}), 64'd0);
        cyc();
        reset = 1'b0;

        // fetch read, 2-edge latency
        fetch_req = 1'b1; fetch_addr = 16'h0010;
        cyc(); fetch_req = 1'b0;
        half();
        chk("f_gnt", 64'(fetch_gnt), 64'd1);
        chk("f_mem_addr", 64'(mem_addr), 64'h10);
        chk("f_valid_early", 64'(fetch_valid), 64'd0);
        cyc(); half();
        chk("f_valid", 64'(fetch_valid), 64'd1);
        chk("f_data", fetch_data, 64'h0123456789ABCDEF);
        chk("f_gnt_pulse", 64'(fetch_gnt), 64'd0);
        cyc(); half();
        chk("f_valid_pulse", 64'(fetch_valid), 64'd0);

        // store then back-to-back load
        data_req = 1'b1; data_we = 1'b1; data_addr = 16'h0020; data_wdata = 64'hDEAD;
        cyc(); data_we = 1'b0;
        half();
        chk("st_gnt", 64'(data_gnt), 64'd1);
        chk("st_mem_we", 64'(mem_we), 64'd1);
        chk("st_mem_addr", 64'(mem_addr), 64'h20);
        chk("st_mem_wdata", mem_wdata, 64'hDEAD);
        cyc(); data_req = 1'b0;
        half();
        chk("st_no_valid", 64'(data_valid), 64'd0);
        chk("ld_gnt", 64'(data_gnt), 64'd1);
        chk("ld_mem_we", 64'(mem_we), 64'd0);
        cyc(); half();
        chk("ld_valid", 64'(data_valid), 64'd1);
        chk("ld_rdata", data_rdata, 64'hDEAD);
        cyc(); half();
        chk("ld_valid_pulse", 64'(data_valid), 64'd0);

        // last in-bounds word
        data_req = 1'b1; data_addr = 16'h03FF;
        cyc(); data_req = 1'b0;
        half();
        chk("edge_trap", 64'(trap), 64'd0);
        cyc(); half();
        chk("edge_valid", 64'(data_valid), 64'd1);
        chk("edge_rdata", data_rdata, 64'h3FF);

        // reset with a load in flight
        cyc();
        data_req = 1'b1; data_addr = 16'h0020;
        cyc(); data_req = 1'b0; reset = 1'b1;
        half();
        chk("rif_gnt", 64'(data_gnt), 64'd1);
        cyc(); reset = 1'b0;
        half();
        chk("rif_outs", 64'({fetch_gnt, data_gnt, data_valid, fetch_valid, mem_we, trap}), 64'd0);
        chk("rif_mem_addr", 64'(mem_addr), 64'd0);
        cyc(); half();
        chk("rif_no_valid", 64'(data_valid), 64'd0);

        // both ports requesting for 4 cycles
        cyc();
        data_req = 1'b1; data_addr = 16'h0001; fetch_req = 1'b1; fetch_addr = 16'h0002;
        n_data = 0; n_fetch = 0;
        for (int i = 0; i < 4; i++) begin
            cyc(); half();
`ifdef MEM_ARB_RR_EN
            chk("rr_data_gnt", 64'(data_gnt), 64'((i % 2) == 0));
            chk("rr_fetch_gnt", 64'(fetch_gnt), 64'((i % 2) == 1));
`endif
            n_data += int'(data_gnt);
            n_fetch += int'(fetch_gnt);
        end
`ifdef MEM_ARB_RR_EN
        chk("both_data_cnt", 64'(n_data), 64'd2);
        chk("both_fetch_cnt", 64'(n_fetch), 64'd2);
`else
        chk("both_data_cnt", 64'(n_data), 64'd4);
        chk("both_fetch_cnt", 64'(n_fetch), 64'd0);
`endif
        cyc(); data_req = 1'b0;
        cyc(); fetch_req = 1'b0;
        half();
        chk("loser_gnt", 64'(fetch_gnt), 64'd1);
        chk("loser_addr", 64'(mem_addr), 64'h2);
        cyc(); cyc(); cyc();

        // flush the cycle after grant
        fetch_req = 1'b1; fetch_addr = 16'h0010;
        cyc(); fetch_req = 1'b0;
        half();
        chk("fl_gnt", 64'(fetch_gnt), 64'd1);
        cyc(); flush = 1'b1;
        half();
        chk("fl_late_kill", 64'(fetch_valid), 64'd0);
        cyc(); flush = 1'b0;
        half();
        chk("fl_after", 64'(fetch_valid), 64'd0);
        // flush in the grant cycle
        fetch_req = 1'b1;
        cyc(); fetch_req = 1'b0; flush = 1'b1;
        cyc(); flush = 1'b0;
        half();
        chk("fl_early_kill", 64'(fetch_valid), 64'd0);
        // following fetch unaffected
        fetch_req = 1'b1;
        cyc(); fetch_req = 1'b0;
        cyc(); half();
        chk("fl_next_valid", 64'(fetch_valid), 64'd1);
        chk("fl_next_data", fetch_data, 64'h0123456789ABCDEF);

        // out-of-bounds load traps
        cyc();
        data_req = 1'b1; data_we = 1'b0; data_addr = 16'h0400;
        cyc(); data_req = 1'b0; fetch_req = 1'b1; fetch_addr = 16'h0010;
        half();
        chk("oob_gnt", 64'(data_gnt), 64'd1);
        chk("oob_mem_we", 64'(mem_we), 64'd0);
        chk("oob_trap", 64'(trap), 64'd1);
        n_fetch = 0; n_data = 0;
        for (int i = 0; i < 4; i++) begin
            cyc(); half();
            n_fetch += int'(fetch_gnt);
            n_data += int'(data_valid);
        end
        chk("trap_no_fgnt", 64'(n_fetch), 64'd0);
        chk("trap_no_dvalid", 64'(n_data), 64'd0);
        chk("trap_sticky", 64'(trap), 64'd1);
        data_req = 1'b1; data_we = 1'b1; data_addr = 16'h0005;
        cyc(); data_req = 1'b0;
        half();
        chk("trap_st_gnt", 64'(data_gnt), 64'd0);
        chk("trap_st_we", 64'(mem_we), 64'd0);
        reset = 1'b1;
        cyc(); reset = 1'b0;
        half();
        chk("trap_clr", 64'(trap), 64'd0);
        cyc(); fetch_req = 1'b0;
        half();
        chk("post_trap_fgnt", 64'(fetch_gnt), 64'd1);

        // out-of-bounds store: granted but never written
        cyc(); cyc();
        data_req = 1'b1; data_we = 1'b1; data_addr = 16'hFFFF; data_wdata = 64'h55;
        cyc(); data_req = 1'b0;
        half();
        chk("oob_st_gnt", 64'(data_gnt), 64'd1);
        chk("oob_st_we", 64'(mem_we), 64'd0);
        chk("oob_st_trap", 64'(trap), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter sharing the single-port synchronous linear-memory RAM between the `cpu` instruction-fetch unit and the load/store unit. It issues at most one memory access per cycle and returns read data with a fixed latency. Out-of-bounds data accesses are blocked and raise a sticky trap that halts all further grants. It sits between the cpu front end / execute stage and the RAM macro.

## Interface
- `ADDR_WIDTH`, 16, word-address width of both ports and the RAM.
- `DATA_WIDTH`, 64, data width (matches operand stack width).
- `MEM_WORDS`, 1024, number of implemented words; data addresses `>= MEM_WORDS` are out of bounds.
- `clk` in 1: single clock, all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `fetch_req` in 1: fetch read request.
- `fetch_addr` in ADDR_WIDTH: fetch word address.
- `fetch_gnt` out 1: one-cycle pulse; fetch request accepted.
- `fetch_valid` out 1: one-cycle pulse; `fetch_data` valid.
- `fetch_data` out DATA_WIDTH: fetch read data.
- `flush` in 1: discard any fetch read in flight (branch taken).
- `data_req` in 1: load/store request.
- `data_we` in 1: 1 = store, 0 = load.
- `data_addr` in ADDR_WIDTH: data word address.
- `data_wdata` in DATA_WIDTH: store data.
- `data_gnt` out 1: one-cycle pulse; data request accepted.
- `data_valid` out 1: one-cycle pulse; `data_rdata` valid (loads only).
- `data_rdata` out DATA_WIDTH: load data.
- `mem_addr` out ADDR_WIDTH, `mem_we` out 1, `mem_wdata` out DATA_WIDTH: registered RAM command.
- `mem_rdata` in DATA_WIDTH: RAM read data, valid one cycle after command.
- `trap` out 1: sticky out-of-bounds trap.

## Operation
- States: RUN, TRAPPED. Reset -> RUN.
- RUN: at each edge, sample requests; select one winner; register its address/we/wdata into `mem_*`; pulse its `*_gnt` in the following cycle. Loser sees no grant and must hold req/addr/wdata stable.
- Default priority: data over fetch (fixed).
- Data request with `data_addr >= MEM_WORDS`: granted (`data_gnt` pulses), `mem_we` forced 0, no `data_valid`, state -> TRAPPED, `trap` = 1.
- TRAPPED: no grants, `mem_we` = 0, no new valids; pending in-flight read still completes. Exit only by `reset`.
- Stores produce `data_gnt` only, no `data_valid`.
- `flush` high in any cycle kills a fetch read issued in that cycle or the previous one: its `fetch_valid` is suppressed. Data reads unaffected.
- Requester may keep `*_req` high after its grant to issue back-to-back; new address is taken in the grant cycle.
- Reset values: `fetch_gnt`, `fetch_valid`, `data_gnt`, `data_valid`, `mem_we`, `trap` = 0; `mem_addr`, `mem_wdata` = 0; `fetch_data`/`data_rdata` follow `mem_rdata`.
- Reset mid-operation: in-flight reads are dropped, no valid pulses after reset.

## Timing
- Edge E0 samples request; cycle after E0: `mem_*` driven, `*_gnt` high.
- Edge E1: RAM captures command; cycle after E1: `*_valid` high, `*_data` = `mem_rdata` (combinational pass-through).
- Read latency: 2 edges request-sampled to valid. Throughput: 1 access/cycle, either port.
- Simultaneous requests: one grant per cycle; loser is granted next cycle if winner drops req.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin; on simultaneous requests, the port not granted most recently wins; pointer resets to favour data.
- Undefined: fixed data-over-fetch priority; a continuously requesting data port starves fetch.

## Test plan
- Fetch read addr 0x10, RAM word 0x10 = 0x0123456789ABCDEF -> `fetch_gnt` 1 cycle after sample, `fetch_valid` with `fetch_data` = 0x0123456789ABCDEF 2 edges after sample.
- Store 0xDEAD at 0x20, then load 0x20 -> `mem_we` high for one cycle, `data_valid` with `data_rdata` = 0xDEAD; no `data_valid` for the store.
- Both ports requesting 4 cycles: default build -> 4 data grants, 0 fetch; `MEM_ARB_RR_EN` -> grants alternate data, fetch, data, fetch.
- Load at 0x0400 with `MEM_WORDS`=1024 -> `data_gnt` pulse, `mem_we` 0, `trap` = 1 and stays; subsequent fetch requests never granted until reset.
- Fetch granted, `flush` asserted next cycle -> no `fetch_valid` for that read; following fetch returns normally.
- `reset` asserted with a load in flight -> all outputs return to reset values next cycle, no `data_valid`, `trap` = 0.
